// File: rtl/bounce_emulator.sv
// bounce_emulator: turns a clean requested switch level into a contact-bounce
// waveform that finishes on the requested level and then holds it.
// Optional feature macro: BOUNCE_EMU_RANDOM_EN. When it is defined, bounce
// segment lengths come from a 16-bit Galois LFSR. When it is not defined, every
// segment lasts 2^(GlitchLog2-1) cycles and Seed is unused.

module bounce_emulator #(
    parameter int          NumBounces   = 4,
    parameter int          GlitchLog2   = 12,
    parameter int          SettleCycles = 1_000_000,
    parameter logic [15:0] Seed         = 16'hACE1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic level_i,
    output logic sw_o,
    output logic busy_o,
    output logic done_tick_o
);

    // One down-counter is shared between bounce segments and the settle
    // period. It must hold both 2^GlitchLog2 and SettleCycles without wrapping.
    localparam int SegW  = GlitchLog2 + 1;
    localparam int SetW  = $clog2(SettleCycles + 1);
    localparam int CntW  = (SegW > SetW) ? SegW : SetW;
    localparam int EdgeW = (NumBounces > 0) ? $clog2(2 * NumBounces + 1) : 1;

    localparam logic [CntW-1:0]  CntOne     = CntW'(1);
    localparam logic [CntW-1:0]  SettleLoad = CntW'(SettleCycles);
    localparam logic [EdgeW-1:0] EdgeOne    = EdgeW'(1);
    localparam logic [EdgeW-1:0] EdgeLoad   = EdgeW'(2 * NumBounces);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BOUNCE = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic             sw_reg, sw_next;
    logic             done_reg, done_next;
    logic [CntW-1:0]  cnt_reg, cnt_next;
    logic [EdgeW-1:0] edges_reg, edges_next;

    // d_first: length of the segment that follows the first edge.
    // d_reload: length of the segment that follows a bounce toggle.
    logic [CntW-1:0]  d_first;
    logic [CntW-1:0]  d_reload;

`ifdef BOUNCE_EMU_RANDOM_EN
    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [15:0] SeedInit = (Seed == 16'h0000) ? 16'h0001 : Seed;

    logic [15:0] lfsr_reg;
    logic [15:0] lfsr_step;
    logic        bounce_edge;

    assign lfsr_step   = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);
    assign d_first     = CntW'(lfsr_reg[GlitchLog2-1:0]) + CntOne;
    assign d_reload    = CntW'(lfsr_step[GlitchLog2-1:0]) + CntOne;
    assign bounce_edge = (state_reg == BOUNCE) && (cnt_reg == CntOne);

    // LFSR advances exactly once per bounce toggle; reset restores the seed.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            lfsr_reg <= SeedInit;
        end else if (bounce_edge) begin
            lfsr_reg <= lfsr_step;
        end
    end
`else
    localparam logic [CntW-1:0] DFixed = CntOne << (GlitchLog2 - 1);

    assign d_first  = DFixed;
    assign d_reload = DFixed;

    // Seed has no effect when segment lengths are fixed.
    if (Seed == 16'h0000) begin : g_seed_unused
    end
`endif

    // State, output level, done pulse and counters; reset wins over everything.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_reg <= IDLE;
            sw_reg    <= 1'b0;
            done_reg  <= 1'b0;
            cnt_reg   <= '0;
            edges_reg <= '0;
        end else begin
            state_reg <= state_next;
            sw_reg    <= sw_next;
            done_reg  <= done_next;
            cnt_reg   <= cnt_next;
            edges_reg <= edges_next;
        end
    end

    // Next-state logic: first edge in IDLE, timed toggles in BOUNCE, hold in SETTLE.
    always_comb begin
        state_next = state_reg;
        sw_next    = sw_reg;
        done_next  = 1'b0;
        cnt_next   = cnt_reg;
        edges_next = edges_reg;

        case (state_reg)
            IDLE: begin
                if (level_i != sw_reg) begin
                    sw_next    = ~sw_reg;
                    edges_next = EdgeLoad;
                    if (NumBounces > 0) begin
                        state_next = BOUNCE;
                        cnt_next   = d_first;
                    end else begin
                        state_next = SETTLE;
                        cnt_next   = SettleLoad;
                    end
                end
            end

            BOUNCE: begin
                cnt_next = cnt_reg - CntOne;
                if (cnt_reg == CntOne) begin
                    sw_next    = ~sw_reg;
                    edges_next = edges_reg - EdgeOne;
                    cnt_next   = d_reload;
                    // The last remaining edge lands on the requested level.
                    if (edges_reg == EdgeOne) begin
                        state_next = SETTLE;
                        cnt_next   = SettleLoad;
                    end
                end
            end

            SETTLE: begin
                cnt_next = cnt_reg - CntOne;
                if (cnt_reg == CntOne) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign sw_o        = sw_reg;
    assign done_tick_o = done_reg;
    assign busy_o      = (state_reg != IDLE);

endmodule

// File: tb/tb_bounce_emulator.sv
// Testbench for bounce_emulator: two instances (NumBounces=3 and NumBounces=0)
// share stimulus; a timeline model predicts sw/busy/done for every cycle.

module tb_bounce_emulator;

    localparam int          G    = 4;
    localparam int          NB_A = 3;
    localparam int          S_A  = 20;
    localparam int          NB_B = 0;
    localparam int          S_B  = 5;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk     = 1'b0;
    logic rst_i   = 1'b0;
    logic level_i = 1'b0;
    logic sw_a, busy_a, done_a;
    logic sw_b, busy_b, done_b;

    bounce_emulator #(
        .NumBounces  (NB_A),
        .GlitchLog2  (G),
        .SettleCycles(S_A),
        .Seed        (SEED)
    ) u_dut_a (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .level_i    (level_i),
        .sw_o       (sw_a),
        .busy_o     (busy_a),
        .done_tick_o(done_a)
    );

    bounce_emulator #(
        .NumBounces  (NB_B),
        .GlitchLog2  (G),
        .SettleCycles(S_B),
        .Seed        (SEED)
    ) u_dut_b (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .level_i    (level_i),
        .sw_o       (sw_b),
        .busy_o     (busy_b),
        .done_tick_o(done_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total  = 0;
    int passes = 0;
    int fails  = 0;

    // Timeline model: each sequence is a list of absolute toggle cycles plus
    // the cycle of its done pulse; the switch is busy strictly before that.
    int   nb     [2];
    int   settle [2];
    logic m_sw   [2];
    int   m_done [2];
    int   tog    [2][16];
    int   tog_n  [2];
    int   tog_i  [2];
`ifdef BOUNCE_EMU_RANDOM_EN
    logic [15:0] m_lfsr [2];
`endif

    task automatic chk(input string tag, input logic got, input logic exp, input int c);
        total++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s cycle=%0d got=%b expected=%b", tag, c, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_sw[i]   = 1'b0;
            m_done[i] = -1;
            tog_n[i]  = 0;
            tog_i[i]  = 0;
`ifdef BOUNCE_EMU_RANDOM_EN
            m_lfsr[i] = SEED;
`endif
        end
    endtask

    // Request accepted in cycle c: first edge at c+1, then 2*nb more edges,
    // each after a segment of d cycles, then the settle hold.
    task automatic schedule(input int i, input int c);
        int t;
        int d;
`ifdef BOUNCE_EMU_RANDOM_EN
        logic [15:0] lf;
        lf = m_lfsr[i];
`endif
        t        = c + 1;
        tog_n[i] = 0;
        tog_i[i] = 0;
        tog[i][tog_n[i]] = t;
        tog_n[i]++;
        for (int k = 0; k < 2 * nb[i]; k++) begin
`ifdef BOUNCE_EMU_RANDOM_EN
            d  = 1 + (int'(lf) % (1 << G));
            lf = (lf >> 1) ^ (lf[0] ? 16'hB400 : 16'h0000);
`else
            d  = 1 << (G - 1);
`endif
            t = t + d;
            tog[i][tog_n[i]] = t;
            tog_n[i]++;
        end
`ifdef BOUNCE_EMU_RANDOM_EN
        m_lfsr[i] = lf;
`endif
        m_done[i] = t + settle[i];
    endtask

    // One clock cycle: check outputs of the current cycle, then drive inputs.
    task automatic step(input logic lvl, input logic rst_n);
        int c;
        @(negedge clk);
        c = cyc;
        for (int i = 0; i < 2; i++) begin
            while (tog_i[i] < tog_n[i] && tog[i][tog_i[i]] == c) begin
                m_sw[i] = ~m_sw[i];
                tog_i[i]++;
            end
        end
        chk("a_sw",   sw_a,   m_sw[0],               c);
        chk("a_busy", busy_a, logic'(c < m_done[0]),  c);
        chk("a_done", done_a, logic'(c == m_done[0]), c);
        chk("b_sw",   sw_b,   m_sw[1],               c);
        chk("b_busy", busy_b, logic'(c < m_done[1]),  c);
        chk("b_done", done_b, logic'(c == m_done[1]), c);
        level_i = lvl;
        rst_i   = rst_n;
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (c >= m_done[i] && lvl != m_sw[i]) schedule(i, c);
            end
        end
    endtask

    task automatic hold(input logic lvl, input int n);
        repeat (n) step(lvl, 1'b1);
    endtask

    initial begin
        nb[0]     = NB_A;
        nb[1]     = NB_B;
        settle[0] = S_A;
        settle[1] = S_B;
        model_reset();

        // Reset with level 0, then 100 quiet cycles.
        rst_i   = 1'b0;
        level_i = 1'b0;
        repeat (2) @(posedge clk);
        hold(1'b0, 100);

        // Full 0->1 sequence, then back to 0.
        hold(1'b1, 90);
        hold(1'b0, 90);

        // 1->0->1 glitch while bouncing, then a later 1->0 request.
        hold(1'b1, 5);
        hold(1'b0, 3);
        hold(1'b1, 100);
        hold(1'b0, 100);

        // Random level changes with random hold times.
        for (int k = 0; k < 60; k++) begin
            hold(logic'($urandom_range(0, 1)), int'($urandom_range(1, 40)));
        end

        // Reset in the middle of a bounce, then a fresh full sequence.
        hold(1'b0, 100);
        hold(1'b1, 20);
        step(1'b1, 1'b0);
        hold(1'b1, 100);
        hold(1'b0, 100);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/bounce_emulator.md
# bounce_emulator

Synthesizable mechanical-switch emulator: converts a clean requested level into a contact-bounce waveform that ends on the new level and holds there. It is the source end of the switch-input path. It drives the raw switch input of the debounce block for on-board self-test and hardware-in-the-loop stimulus, without a physical button. Bounce segment lengths come from an internal LFSR, or from a fixed value when the random feature is compiled out.

## Interface
Parameters:
- `NumBounces`, default 4: number of return pulses to the old level per transition. Total edges per transition = 2·NumBounces+1. 0 is legal.
- `GlitchLog2`, default 12: segment length range exponent, 1..16.
- `SettleCycles`, default 1_000_000: cycles the final level is held before completion, ≥1.
- `Seed`, default 16'hACE1: LFSR reset value. 0 is replaced by 16'h0001.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, synchronous, active-low.
- `level_i` in 1: clean requested switch level.
- `sw_o` out 1: emulated bouncy switch output, registered.
- `busy_o` out 1: high while a transition sequence is in progress.
- `done_tick_o` out 1: one-cycle pulse when a sequence completes, registered.

## Operation
- FSM states: IDLE, BOUNCE, SETTLE.
- IDLE:
  - If `level_i != sw_o`: toggle `sw_o` (first edge), set the remaining-edge counter to 2·NumBounces, and load the segment counter with d.
  - Next state is BOUNCE if NumBounces>0. Otherwise it is SETTLE, with the settle counter loaded with SettleCycles.
- BOUNCE:
  - Segment counter decrements each cycle.
  - At count 1: toggle `sw_o`, decrement the remaining-edge counter, advance the LFSR, and reload the segment counter with the new d.
  - When the last remaining edge is issued, enter SETTLE and load the settle counter.
- SETTLE:
  - Counter decrements each cycle.
  - At count 1: next state IDLE, and `done_tick_o`=1 in the first IDLE cycle.
- Segment length d = 1 + LFSR[GlitchLog2-1:0], range 1..2^GlitchLog2.
- LFSR: 16-bit Galois, taps mask 16'hB400, shifted once per bounce toggle. It never reaches 0.
- `level_i` is ignored outside IDLE. A change during BOUNCE/SETTLE is re-evaluated in IDLE. If `level_i` then differs from `sw_o`, a new sequence starts, which may be in the same cycle as `done_tick_o`.
- The final level of every sequence equals the level latched at the first edge, since the edge count is odd.
- Counter widths ≥ max(GlitchLog2+1, clog2(SettleCycles+1)). No wrap-around is permitted.

## Timing
- Reset (`rst_i`=0 at a clock edge):
  - `sw_o`=0, `busy_o`=0, `done_tick_o`=0.
  - State IDLE, LFSR=Seed, all counters 0.
  - This applies from any state, including mid-BOUNCE. Reset has priority over all transitions.
- Latency: `level_i` sampled differing at edge T → `sw_o` changes in cycle T+1.
- Every level between consecutive toggles is held exactly d cycles.
- Final level held SettleCycles cycles, then `done_tick_o` pulses for exactly 1 cycle.
- `busy_o` = (state != IDLE), decoded from the state register. It is high from the first-edge cycle through the last SETTLE cycle.
- `level_i` is used directly. The caller guarantees it is synchronous to `clk_i`.

## Configuration
- `BOUNCE_EMU_RANDOM_EN` defined: d is drawn from the LFSR as above. The sequence is reproducible for a given Seed.
- Not defined: LFSR logic is omitted and every segment is d = 2^(GlitchLog2-1) cycles. The Seed parameter has no effect. All other behaviour is identical.

## Test plan
1. Reset, level_i=0: `sw_o`=0, `busy_o`=0, `done_tick_o`=0. Hold 100 cycles with no activity.
2. Macro off, NumBounces=3, GlitchLog2=4, SettleCycles=20; level_i 0→1 sampled at cycle 10 →
   - `sw_o`=1 at 11, 0 at 19, 1 at 27, 0 at 35, 1 at 43, 0 at 51, 1 at 59.
   - `done_tick_o`=1 only at 79.
   - `busy_o` high for cycles 11–78.
3. Same config, level_i 1→0→1 glitch during BOUNCE: ignored; sequence ends at 1. A later 1→0 request starts a new 7-edge sequence ending at `sw_o`=0.
4. NumBounces=0, SettleCycles=5: a single edge at T+1, `done_tick_o` at T+6, no other toggles.
5. Macro on, Seed=16'hACE1, GlitchLog2=4:
   - Every hold interval is within [1,16] and the LFSR is never 0.
   - Two runs from reset produce identical `sw_o` traces.
   - The final level equals the request.
6. Reset asserted mid-BOUNCE: next cycle `sw_o`=0, `busy_o`=0, no `done_tick_o`, LFSR=Seed. The next request restarts a full sequence.
